clk_divider_prog: RTL and testbench
===================================

Name: clk_divider_prog

Overview:
- Runtime-programmable clock divider; successor to the fixed even/odd/half/float dividers.
- One instance covers integer ratios (even or odd, optional true 50% duty on odd) and fractional ratios N + F/2^FRAC_W via a dual-modulus accumulator.
- Ratio changes take effect glitch-free at output-period boundaries.
- Sits in clock-generation logic, driven from a config register block.

Parameters:
- CNT_W, 8, width of integer divide field; N range 2..2^CNT_W-1.
- FRAC_W, 4, width of fractional field F.
- DEFAULT_N, 4, integer ratio loaded at reset; must be ≥2.
- DUTY50, 0, when 1 and active F==0 and N odd, stretch high phase by half a source cycle using a negedge flop.

Ports:
- clk  in  1  source clock; all logic on posedge except DUTY50 negedge flop.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new ratio request.
- cfg_n  in  CNT_W  requested integer part N.
- cfg_f  in  FRAC_W  requested fractional part F.
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready.
- cfg_err  out  1  one-cycle pulse: request with cfg_n<2 rejected.
- clk_div  out  1  divided clock.
- tick  out  1  high during last source cycle of each output period.

Behaviour:
- Reset (rst sampled high at posedge):
  - active N=DEFAULT_N, F=0, acc=0, cnt=P-1 where P=DEFAULT_N.
  - pending=0, cfg_ready=1, cfg_err=0, clk_div=0, tick=0, negedge flop=0.
  - rst asserted mid-period aborts immediately; a pending config is discarded.
- Period: counter cnt runs 0..P-1.
  - At cnt==P-1 (boundary), the next posedge starts a new period: cnt←0.
  - P for the new period = N + carry, where {carry, acc} ← acc + F (FRAC_W-bit acc, carry out).
- clk_div is a registered output, value = (cnt_next < floor(P/2)). It is high for floor(P/2) cycles, then low for ceil(P/2) cycles.
- First posedge with rst low starts a period, so clk_div rises there.
- tick is registered, tick = (cnt_next == P-1).
- DUTY50 (active F==0, N odd):
  - negedge flop samples the posedge clk_div register.
  - Output clk_div = posedge reg OR negedge reg.
  - Result: high (N/2) cycles exactly (e.g. 2.5), low the same.
  - In all other cases the negedge path is forced 0.
- Config handshake:
  - Accept when cfg_valid & cfg_ready & cfg_n≥2: store to shadow, pending←1, cfg_ready←0 next cycle.
  - Rejection (cfg_valid & cfg_ready & cfg_n<2): cfg_err high for the next cycle only. Shadow untouched; cfg_ready stays 1.
- Apply: at the boundary cycle with pending=1:
  - next period uses shadow N,F with acc reset to 0 (carry computed from 0+F).
  - pending←0, cfg_ready←1 on the following cycle.
- Acceptance in the boundary cycle itself: the new ratio applies at the NEXT boundary (one full old period later), never the current one.
- No glitches: clk_div never produces a pulse shorter than floor(P_min/2) source cycles across a reconfig.
- Width: acc and carry exactly FRAC_W+1 bits; cnt is CNT_W+1 bits so P=2^CNT_W-1+1 fits.

Test Plan:
- DEFAULT_N=4, rst 20 cycles then release -> clk_div rises at first posedge, then 2 high / 2 low, period 40 ns at 100 MHz; tick high in each 4th cycle.
- cfg N=5, F=0, DUTY50=0 -> after boundary: 2 high / 3 low. With DUTY50=1 -> 25 ns high / 25 ns low, edges on clk negedge.
- cfg N=8, F=10 (FRAC_W=4, 8.625) -> over 16 periods: exactly 10 periods of 9 and 6 of 8 cycles, 138 cycles total, repeating. First period is 8.
- cfg request in mid-period -> cfg_ready low next cycle; old ratio completes; new ratio from next boundary; cfg_ready high one cycle after apply. A second request while cfg_ready=0 is not taken.
- cfg_n=1 -> cfg_err one-cycle pulse; ratio unchanged; cfg_ready stays 1.
- rst asserted mid-period with pending config -> all outputs reset next edge; after release, DEFAULT_N ratio, not the pending one.

Source files
------------

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider: integer N or fractional N + F/2^FRAC_W via a dual-modulus
// accumulator, with glitch-free ratio switching at output-period boundaries.
module clk_divider_prog #(
    parameter int CNT_W     = 8,
    parameter int FRAC_W    = 4,
    parameter int DEFAULT_N = 4,
    parameter int DUTY50    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_n,
    input  logic [FRAC_W-1:0] cfg_f,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              clk_div,
    output logic              tick
);

    localparam int CW = CNT_W + 1;
    localparam logic [CW-1:0]    ONE   = CW'(1);
    localparam logic [CNT_W-1:0] N_MIN = CNT_W'(2);

    // active ratio, shadow (pending) ratio, accumulator and period counter
    logic [CNT_W-1:0]  n_act;
    logic [FRAC_W-1:0] f_act;
    logic [FRAC_W-1:0] acc;
    logic [CNT_W-1:0]  sh_n;
    logic [FRAC_W-1:0] sh_f;
    logic              pending;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     p_cur;
    logic              pos_q;
    logic              neg_q;
    logic              neg_en;

    logic              boundary;
    logic              accept;
    logic              reject;
    logic [CNT_W-1:0]  use_n;
    logic [FRAC_W-1:0] use_f;
    logic [FRAC_W-1:0] acc_base;
    logic [FRAC_W:0]   sum;
    logic [CW-1:0]     p_new;
    logic [CW-1:0]     cnt_nx;
    logic [CW-1:0]     p_nx;
    logic [CW-1:0]     half_nx;

    always_comb begin
        boundary = (cnt == p_cur - ONE);
        accept   = cfg_valid && cfg_ready && (cfg_n >= N_MIN);
        reject   = cfg_valid && cfg_ready && (cfg_n < N_MIN);
        // a pending ratio restarts the accumulator from zero
        use_n    = pending ? sh_n : n_act;
        use_f    = pending ? sh_f : f_act;
        acc_base = pending ? '0 : acc;
        sum      = {1'b0, acc_base} + {1'b0, use_f};
        p_new    = {1'b0, use_n} + {{CNT_W{1'b0}}, sum[FRAC_W]};
        cnt_nx   = boundary ? '0 : cnt + ONE;
        p_nx     = boundary ? p_new : p_cur;
        half_nx  = p_nx >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_act     <= CNT_W'(DEFAULT_N);
            f_act     <= '0;
            acc       <= '0;
            cnt       <= CW'(DEFAULT_N - 1);
            p_cur     <= CW'(DEFAULT_N);
            pending   <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            pos_q     <= 1'b0;
            tick      <= 1'b0;
            neg_en    <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            p_cur   <= p_nx;
            pos_q   <= (cnt_nx < half_nx);
            tick    <= (cnt_nx == p_nx - ONE);
            cfg_err <= reject;
            if (boundary) begin
                acc    <= sum[FRAC_W-1:0];
                n_act  <= use_n;
                f_act  <= use_f;
                neg_en <= (DUTY50 != 0) && (use_f == '0) && use_n[0];
            end
            // accept is only possible while nothing is pending, so the two arms never collide
            if (accept) begin
                pending   <= 1'b1;
                cfg_ready <= 1'b0;
            end else if (boundary && pending) begin
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sh_n <= cfg_n;
            sh_f <= cfg_f;
        end
    end

    // half-cycle delayed copy of the high phase; only contributes in odd-N 50% duty mode
    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_div = pos_q | (neg_q & neg_en);

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: vector table for handshake/ratio basics, hand sequences
// for boundary acceptance, fractional ratio, 50% duty odd ratio and mid-period reset.
module tb_clk_divider_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [7:0] cfg_n;
    logic [3:0] cfg_f;
    logic       cfg_ready, cfg_err, clk_div, tick;
    logic       cfg_ready2, cfg_err2, clk_div2, tick2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_divider_prog #(.CNT_W(8), .FRAC_W(4), .DEFAULT_N(4), .DUTY50(0)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_n(cfg_n), .cfg_f(cfg_f),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_div(clk_div), .tick(tick)
    );

    clk_divider_prog #(.CNT_W(8), .FRAC_W(4), .DEFAULT_N(4), .DUTY50(1)) dut50 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_n(cfg_n), .cfg_f(cfg_f),
        .cfg_ready(cfg_ready2), .cfg_err(cfg_err2), .clk_div(clk_div2), .tick(tick2)
    );

    typedef struct {
        logic       v;
        logic [7:0] n;
        logic [3:0] f;
        logic       e_clk;
        logic       e_tick;
        logic       e_rdy;
        logic       e_err;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input int v, input int n, input int f,
                                input int c, input int t, input int r, input int e);
        vec_t x;
        x.v      = 1'(v);
        x.n      = 8'(n);
        x.f      = 4'(f);
        x.e_clk  = 1'(c);
        x.e_tick = 1'(t);
        x.e_rdy  = 1'(r);
        x.e_err  = 1'(e);
        return x;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick(output int len);
        len = 0;
        do begin
            step();
            len++;
        end while (!tick && len < 300);
        if (len >= 300) check("tick_timeout", len, 0);
    endtask

    task automatic send(input int n, input int f);
        cfg_valid = 1'b1;
        cfg_n     = 8'(n);
        cfg_f     = 4'(f);
        step();
        cfg_valid = 1'b0;
    endtask

    int len;
    int sum;
    int exp_len[16] = '{8, 9, 8, 9, 9, 8, 9, 9, 8, 9, 8, 9, 9, 8, 9, 9};
    logic samp[20];

    initial begin
        // default ratio 4, reject of n=1, mid-period accept of 5, ignored second request
        tbl[0]  = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[5]  = mk(1, 1, 0, 1, 0, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[9]  = mk(1, 5, 0, 1, 0, 0, 0);
        tbl[10] = mk(1, 9, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 1, 1, 0);
        tbl[17] = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 0, 0, 1, 1, 0);

        rst = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_f = '0;
        repeat (20) step();
        check("rst_clk", clk_div, 0);
        check("rst_tick", tick, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_err", cfg_err, 0);
        check("rst_clk50", clk_div2, 0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cfg_valid = tbl[i].v;
            cfg_n     = tbl[i].n;
            cfg_f     = tbl[i].f;
            step();
            check($sformatf("tbl%0d_clk", i), clk_div, tbl[i].e_clk);
            check($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
            check($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
        end
        cfg_valid = 1'b0;

        // accept in the boundary cycle: old ratio runs one more full period
        send(3, 0);
        check("bnd_ready", cfg_ready, 0);
        next_tick(len);
        check("bnd_old_period_rest", len, 4);
        next_tick(len);
        check("bnd_new_period", len, 3);
        check("bnd_ready_after", cfg_ready, 1);
        next_tick(len);
        check("bnd_new_period2", len, 3);

        // fractional 8 + 10/16
        send(8, 10);
        if (!tick) next_tick(len);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            next_tick(len);
            sum += len;
            check($sformatf("frac_p%0d", i), len, exp_len[i]);
        end
        check("frac_total", sum, 138);

        // odd ratio 5: plain 2/3 versus 50% duty 2.5/2.5 sampled on both edges
        send(5, 0);
        if (!tick) next_tick(len);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            samp[2*i] = clk_div2;
            check($sformatf("odd_clk_c%0d", i), clk_div, ((i % 5) < 2) ? 1 : 0);
            @(negedge clk); #1;
            samp[2*i+1] = clk_div2;
        end
        for (int k = 0; k < 20; k++)
            check($sformatf("duty50_h%0d", k), samp[k], ((k % 10) < 5) ? 1 : 0);

        // reset mid-period with a pending ratio: pending is dropped
        send(7, 0);
        check("pend_ready", cfg_ready, 0);
        step();
        rst = 1'b1;
        step();
        check("midrst_clk", clk_div, 0);
        check("midrst_tick", tick, 0);
        check("midrst_ready", cfg_ready, 1);
        check("midrst_err", cfg_err, 0);
        check("midrst_clk50", clk_div2, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rel_c0_clk", clk_div, 1);
        check("rel_c0_tick", tick, 0);
        step();
        check("rel_c1_clk", clk_div, 1);
        step();
        check("rel_c2_clk", clk_div, 0);
        step();
        check("rel_c3_clk", clk_div, 0);
        check("rel_c3_tick", tick, 1);
        next_tick(len);
        check("rel_period1", len, 4);
        next_tick(len);
        check("rel_period2", len, 4);
        check("rel_ready", cfg_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
